// File: rtl/muldiv_pkg.sv
// Shared constants, state encoding and operation predicates for the
// iterative RV64M multiply/divide unit.
package muldiv_pkg;

    localparam int XLEN = 64;

    localparam logic [2:0] OP_MUL    = 3'b000;
    localparam logic [2:0] OP_MULH   = 3'b001;
    localparam logic [2:0] OP_MULHSU = 3'b010;
    localparam logic [2:0] OP_MULHU  = 3'b011;
    localparam logic [2:0] OP_DIV    = 3'b100;
    localparam logic [2:0] OP_DIVU   = 3'b101;
    localparam logic [2:0] OP_REM    = 3'b110;
    localparam logic [2:0] OP_REMU   = 3'b111;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FAST = 2'd2,
        FIN  = 2'd3
    } state_e;

    function automatic logic is_div(input logic [2:0] op);
        return op[2];
    endfunction

    function automatic logic is_rem(input logic [2:0] op);
        return op[2] & op[1];
    endfunction

    function automatic logic mul_high(input logic [2:0] op);
        return (op == OP_MULH) || (op == OP_MULHSU) || (op == OP_MULHU);
    endfunction

    function automatic logic a_signed(input logic [2:0] op);
        return !((op == OP_MULHU) || (op == OP_DIVU) || (op == OP_REMU));
    endfunction

    function automatic logic b_signed(input logic [2:0] op);
        return (op == OP_MUL) || (op == OP_MULH) || (op == OP_DIV) || (op == OP_REM);
    endfunction

endpackage

// File: rtl/muldiv_64_bit.sv
// Radix-2 iterative multiply/divide: shift-add multiply and restoring divide
// on operand magnitudes, sharing one adder, with sign fix-up on the way out.
module muldiv_64_bit #(
    parameter int XLEN = muldiv_pkg::XLEN,
    parameter int ITER = XLEN
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    input  logic [2:0]      op,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] Result,
    output logic [1:0]      dbg_state_o
);
    import muldiv_pkg::*;

    localparam int CW = $clog2(ITER);
    localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

    // Handshake: start is a request only while IDLE (busy=0, done=0); the
    // unit answers with exactly one done pulse whose cycle carries Result.
    state_e            state_q;
    logic [CW-1:0]     cnt_q;
    logic [2:0]        op_q;
    logic              neg_q;
    logic [XLEN-1:0]   hi_q, lo_q, dvs_q;
    logic              busy_q, done_q;
    logic [XLEN-1:0]   result_q;

    logic              a_neg, b_neg, b_zero, div_ovf, take_fast;
    logic [XLEN-1:0]   a_mag, b_mag;

    always_comb begin
        a_neg     = a_signed(op) & a[XLEN-1];
        b_neg     = b_signed(op) & b[XLEN-1];
        a_mag     = a_neg ? -a : a;
        b_mag     = b_neg ? -b : b;
        b_zero    = (b == '0);
        div_ovf   = ((op == OP_DIV) || (op == OP_REM)) && (a == MIN_NEG) && (b == '1);
        take_fast = is_div(op) && (b_zero || div_ovf);
    end

    logic              mul_mode, cin;
    logic [XLEN:0]     shifted;
    logic [XLEN+1:0]   as_a, as_b, sum;
    logic [XLEN-1:0]   hi_n, lo_n, hi_d, lo_d, div_val;
    logic [2*XLEN-1:0] prod, prod_s;
    logic [XLEN-1:0]   result_d;

    always_comb begin
        mul_mode = !is_div(op_q);
        shifted  = {hi_q, lo_q[XLEN-1]};
        // One adder: accumulate multiplicand, or subtract divisor via ~d + 1.
        as_a = mul_mode ? {2'b00, hi_q} : {1'b0, shifted};
        as_b = mul_mode ? (lo_q[0] ? {2'b00, dvs_q} : '0) : ~{2'b00, dvs_q};
        cin  = !mul_mode;
        sum  = as_a + as_b + {{(XLEN+1){1'b0}}, cin};

        if (mul_mode) begin
            hi_n = sum[XLEN:1];
            lo_n = {sum[0], lo_q[XLEN-1:1]};
        end else if (!sum[XLEN+1]) begin
            hi_n = sum[XLEN-1:0];
            lo_n = {lo_q[XLEN-2:0], 1'b1};
        end else begin
            hi_n = shifted[XLEN-1:0];
            lo_n = {lo_q[XLEN-2:0], 1'b0};
        end

        hi_d = (state_q == CALC) ? hi_n : hi_q;
        lo_d = (state_q == CALC) ? lo_n : lo_q;

        prod    = {hi_d, lo_d};
        prod_s  = neg_q ? -prod : prod;
        div_val = is_rem(op_q) ? hi_d : lo_d;
        if (mul_mode) begin
            result_d = mul_high(op_q) ? prod_s[2*XLEN-1:XLEN] : prod_s[XLEN-1:0];
        end else begin
            result_d = neg_q ? -div_val : div_val;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            op_q     <= OP_MUL;
            neg_q    <= 1'b0;
            hi_q     <= '0;
            lo_q     <= '0;
            dvs_q    <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            result_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    done_q <= 1'b0;
                    if (start) begin
                        op_q   <= op;
                        dvs_q  <= b_mag;
                        busy_q <= 1'b1;
                        if (take_fast) begin
                            // Special-case answer preloaded so FIN picks it unchanged.
                            neg_q   <= 1'b0;
                            hi_q    <= b_zero ? a : '0;
                            lo_q    <= b_zero ? '1 : MIN_NEG;
                            state_q <= FAST;
                        end else begin
                            neg_q   <= is_rem(op) ? a_neg : (a_neg ^ b_neg);
                            hi_q    <= '0;
                            lo_q    <= a_mag;
                            cnt_q   <= CW'(ITER - 1);
                            state_q <= CALC;
                        end
                    end
                end
                CALC: begin
                    hi_q <= hi_d;
                    lo_q <= lo_d;
                    if (cnt_q == '0) begin
                        state_q  <= FIN;
                        busy_q   <= 1'b0;
                        done_q   <= 1'b1;
                        result_q <= result_d;
                    end else begin
                        cnt_q <= cnt_q - CW'(1);
                    end
                end
                FAST: begin
                    state_q  <= FIN;
                    busy_q   <= 1'b0;
                    done_q   <= 1'b1;
                    result_q <= result_d;
                end
                FIN: begin
                    done_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign busy        = busy_q;
    assign done        = done_q;
    assign Result      = result_q;
    assign dbg_state_o = state_q;

endmodule
